// File: rtl/ins_pkg.sv
// Shared opcodes, one-hot FSM states and opcode-length helper for the fetch controller.
// Latency: n/a (definitions only); no flow control.
package ins_pkg;

    localparam logic [3:0] OP_MOVI = 4'b0010;
    localparam logic [3:0] OP_HALT = 4'b0011;
    localparam logic [3:0] OP_JMP  = 4'b1010;
    localparam logic [3:0] OP_JG   = 4'b1011;

    typedef enum logic [6:0] {
        IDLE  = 7'b000_0001,
        FETCH = 7'b000_0010,
        LATCH = 7'b000_0100,
        OPF   = 7'b000_1000,
        OPL   = 7'b001_0000,
        EXEC  = 7'b010_0000,
        HALT  = 7'b100_0000
    } state_t;

    // Bit positions in the one-hot vector, used to decode outputs straight off a flop.
    localparam int EXEC_BIT = 5;
    localparam int HALT_BIT = 6;

    function automatic logic is_two_byte(input logic [3:0] op);
        return (op == OP_MOVI) || (op == OP_JMP) || (op == OP_JG);
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: load wins over increment, wraps modulo 2^ADDR_W.
// Latency: updates on the next edge; also exposes the next value combinationally.
module pc_reg #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] value,
    output logic [ADDR_W-1:0] next_value
);

    always_comb begin
        next_value = value;
        if (load)
            next_value = load_val;
        else if (inc)
            next_value = value + ADDR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            value <= '0;
        else
            value <= next_value;
    end

endmodule

// File: rtl/ins_fetch_ctrl.sv
// Fetch/sequence controller feeding the decoder: 3 cycles per 1-byte, 5 per 2-byte instruction.
// Stalls in EXEC while ex_wait is high; run is only honoured in IDLE.
module ins_fetch_ctrl
    import ins_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [3:0]        ir,
    output logic [3:0]        ir_lo,
    output logic [7:0]        imm,
    output logic              en,
    input  logic              flag_gt,
    input  logic              ex_wait,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    state_t            state, state_nxt;
    logic [6:0]        state_vec;
    logic              pc_inc, pc_load;
    logic              ir_ld, imm_ld;
    logic [ADDR_W-1:0] pc_nxt;

    pc_reg #(.ADDR_W(ADDR_W)) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        (pc_inc),
        .load       (pc_load),
        .load_val   (ADDR_W'(imm)),
        .value      (pc),
        .next_value (pc_nxt)
    );

    always_comb begin
        state_nxt = state;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        ir_ld     = 1'b0;
        imm_ld    = 1'b0;
        case (state)
            IDLE:  if (run) state_nxt = FETCH;
            FETCH: state_nxt = LATCH;
            LATCH: begin
                ir_ld     = 1'b1;
                pc_inc    = 1'b1;
                // Decide length from the byte being latched; it is the same opcode ir takes.
                state_nxt = is_two_byte(rom_data[7:4]) ? OPF : EXEC;
            end
            OPF:   state_nxt = OPL;
            OPL: begin
                imm_ld    = 1'b1;
                pc_inc    = 1'b1;
                state_nxt = EXEC;
            end
            EXEC: begin
                if (!ex_wait) begin
                    if (ir == OP_HALT) begin
                        state_nxt = HALT;
                    end else begin
                        pc_load   = (ir == OP_JMP) || ((ir == OP_JG) && flag_gt);
                        state_nxt = FETCH;
                    end
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // rom_addr shadows the next pc so the ROM sees the fetch address as a flop output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rom_addr <= '0;
            ir       <= '0;
            ir_lo    <= '0;
            imm      <= '0;
        end else begin
            rom_addr <= pc_nxt;
            if (ir_ld) begin
                ir    <= rom_data[7:4];
                ir_lo <= rom_data[3:0];
            end
            if (imm_ld)
                imm <= rom_data[7:0];
        end
    end

    assign state_vec = state;
    assign en        = state_vec[EXEC_BIT];
    assign halted    = state_vec[HALT_BIT];

endmodule
